// File: rtl/prog_arb_pkg.sv
// Shared encodings for the program-memory arbiter.
package prog_arb_pkg;

  // Owner of a memory access / round-robin pointer value
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  // Arbiter state; ST_LOCK is only reachable when BURST_LOCK_EN is defined
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage : prog_arb_pkg

// File: rtl/prog_arb.sv
// Two-requester round-robin arbiter in front of the single-port program memory.
// The CPU fetch port and the loader port share the memory; one access per
// cycle, read data is tagged with its owner and returned one cycle later.
// Optional feature macro: BURST_LOCK_EN (loader exclusive burst via ldr_lock).
module prog_arb
  import prog_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e              state_q, state_d;
  owner_e              rr_ptr_q, rr_ptr_d;
  owner_e              ptr_eff;
  logic                lock_hold;
  logic                rd_pend_q, rd_pend_d;
  owner_e              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0]   last_addr_q;

`ifndef BURST_LOCK_EN
  // Lock request has no effect in the plain round-robin build
  logic unused_lock;
  assign unused_lock = ldr_lock;
`endif

  // Next-state, grant and round-robin pointer logic
  always_comb begin
    cpu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ptr_eff   = rr_ptr_q;
    lock_hold = 1'b0;
`ifdef BURST_LOCK_EN
    if (state_q == ST_LOCK) begin
      if (ldr_lock) begin
        lock_hold = 1'b1;
      end else begin
        // Leaving the burst hands priority back to the CPU
        state_d  = ST_ARB;
        ptr_eff  = OWN_LDR;
        rr_ptr_d = OWN_LDR;
      end
    end
`endif
    if (!rst) begin
      if (lock_hold) begin
        ldr_gnt = ldr_req;
      end else if (cpu_req && ldr_req) begin
        if (ptr_eff == OWN_LDR) cpu_gnt = 1'b1;
        else                    ldr_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        ldr_gnt = ldr_req;
      end
      if (cpu_gnt) rr_ptr_d = OWN_CPU;
      if (ldr_gnt) rr_ptr_d = OWN_LDR;
`ifdef BURST_LOCK_EN
      if ((state_q == ST_ARB) && ldr_gnt && ldr_lock) state_d = ST_LOCK;
`endif
    end
  end

  // Read-return tag: any CPU grant or a loader read-back produces a return
  always_comb begin
    rd_pend_d  = cpu_gnt | (ldr_gnt & ~ldr_we);
    rd_owner_d = cpu_gnt ? OWN_CPU : OWN_LDR;
  end

  // Memory port mux; address holds when idle
  always_comb begin
    if (ldr_gnt)      mem_addr = ldr_addr;
    else if (cpu_gnt) mem_addr = cpu_addr;
    else              mem_addr = last_addr_q;
    mem_we  = ldr_gnt & ldr_we;
    mem_din = ldr_wdata;
  end

  // State, pointer, return tag and held address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= OWN_LDR;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_CPU;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      last_addr_q <= mem_addr;
    end
  end

  // Return routing; a pending return is suppressed while reset is asserted
  always_comb begin
    cpu_rvalid = rd_pend_q & (rd_owner_q == OWN_CPU) & ~rst;
    ldr_rvalid = rd_pend_q & (rd_owner_q == OWN_LDR) & ~rst;
    cpu_rdata  = mem_dout;
    ldr_rdata  = mem_dout;
  end

endmodule : prog_arb

// File: tb/tb_prog_arb.sv
// Directed self-checking bench for prog_arb with a behavioural program memory
// (registered read, read-before-write).
module tb_prog_arb;

  logic       clk;
  logic       rst;
  logic       cpu_req;
  logic [7:0] cpu_addr;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       ldr_req;
  logic       ldr_we;
  logic [7:0] ldr_addr;
  logic [7:0] ldr_wdata;
  logic       ldr_lock;
  logic       ldr_gnt;
  logic       ldr_rvalid;
  logic [7:0] ldr_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;

  logic [7:0] mem [256];

  int checks;
  int failures;

  prog_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_lock   (ldr_lock),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory model: old data is read when writing the same address
  always @(posedge clk) begin
    mem_dout <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req   = 1'b0;
    ldr_req   = 1'b0;
    ldr_lock  = 1'b0;
    ldr_we    = 1'b0;
  endtask

  logic exp_ldr;
  int   nw;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h3C;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem_dout  = 8'h00;
    rst       = 1'b1;
    cpu_addr  = 8'h00;
    ldr_addr  = 8'h00;
    ldr_wdata = 8'h00;
    idle_inputs();

    // Reset: grants forced low even with requests present
    tick();
    cpu_req = 1'b1;
    ldr_req = 1'b1;
    settle();
    check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_eq("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
    check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check_eq("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    tick();

    // 1: single CPU fetch
    rst = 1'b0;
    idle_inputs();
    cpu_req  = 1'b1;
    cpu_addr = 8'h05;
    settle();
    check_eq("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("t1_ldr_gnt", 32'(ldr_gnt), 32'd0);
    check_eq("t1_mem_we", 32'(mem_we), 32'd0);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'h05);
    tick();
    cpu_req = 1'b0;
    check_eq("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("t1_cpu_rdata", 32'(cpu_rdata), 32'h3C);
    check_eq("t1_ldr_rvalid", 32'(ldr_rvalid), 32'd0);

    // 2: contention; pointer is CPU so the loader goes first, then alternate
    cpu_req  = 1'b1;
    cpu_addr = 8'h01;
    ldr_req  = 1'b1;
    ldr_we   = 1'b0;
    ldr_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      exp_ldr = ((i % 2) == 0);
      settle();
      check_eq($sformatf("t2_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(!exp_ldr));
      check_eq($sformatf("t2_ldr_gnt%0d", i), 32'(ldr_gnt), 32'(exp_ldr));
      check_eq($sformatf("t2_mem_addr%0d", i), 32'(mem_addr), exp_ldr ? 32'h02 : 32'h01);
      tick();
      check_eq($sformatf("t2_cpu_rvalid%0d", i), 32'(cpu_rvalid), 32'(!exp_ldr));
      check_eq($sformatf("t2_ldr_rvalid%0d", i), 32'(ldr_rvalid), 32'(exp_ldr));
      if (exp_ldr) check_eq($sformatf("t2_ldr_rdata%0d", i), 32'(ldr_rdata), 32'h22);
      else         check_eq($sformatf("t2_cpu_rdata%0d", i), 32'(cpu_rdata), 32'h11);
    end
    idle_inputs();

    // 3: loader write then CPU read of the same address
    ldr_req   = 1'b1;
    ldr_we    = 1'b1;
    ldr_addr  = 8'h10;
    ldr_wdata = 8'hA5;
    settle();
    check_eq("t3_ldr_gnt", 32'(ldr_gnt), 32'd1);
    check_eq("t3_mem_we", 32'(mem_we), 32'd1);
    check_eq("t3_mem_addr", 32'(mem_addr), 32'h10);
    check_eq("t3_mem_din", 32'(mem_din), 32'hA5);
    tick();
    idle_inputs();
    cpu_req  = 1'b1;
    cpu_addr = 8'h10;
    settle();
    check_eq("t3_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("t3_mem_we_rd", 32'(mem_we), 32'd0);
    check_eq("t3_wr_no_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    check_eq("t3_wr_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();
    cpu_req = 1'b0;
    check_eq("t3_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("t3_cpu_rdata", 32'(cpu_rdata), 32'hA5);

    // 6: idle cycles, address holds
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("t6_cpu_gnt%0d", i), 32'(cpu_gnt), 32'd0);
      check_eq($sformatf("t6_ldr_gnt%0d", i), 32'(ldr_gnt), 32'd0);
      check_eq($sformatf("t6_mem_we%0d", i), 32'(mem_we), 32'd0);
      check_eq($sformatf("t6_mem_addr%0d", i), 32'(mem_addr), 32'h10);
      tick();
      check_eq($sformatf("t6_rvalid%0d", i), 32'({cpu_rvalid, ldr_rvalid}), 32'd0);
    end

    // 4: reset right after a CPU grant drops the return and resets the pointer
    cpu_req  = 1'b1;
    cpu_addr = 8'h05;
    settle();
    check_eq("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    rst     = 1'b1;
    cpu_req = 1'b0;
    settle();
    check_eq("t4_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check_eq("t4_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("t4_post_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    cpu_req  = 1'b1;
    cpu_addr = 8'h01;
    ldr_req  = 1'b1;
    ldr_we   = 1'b0;
    ldr_addr = 8'h02;
    settle();
    check_eq("t4_tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("t4_tie_ldr_gnt", 32'(ldr_gnt), 32'd0);
    tick();
    check_eq("t4_cpu_rdata", 32'(cpu_rdata), 32'h11);
    settle();
    check_eq("t4_next_ldr_gnt", 32'(ldr_gnt), 32'd1);
    tick();
    idle_inputs();
    check_eq("t4_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
    check_eq("t4_ldr_rdata", 32'(ldr_rdata), 32'h22);

    // Lone CPU fetch so the pointer is CPU before the burst
    cpu_req  = 1'b1;
    cpu_addr = 8'h05;
    tick();
    idle_inputs();
    tick();

    // 5: locked loader burst against a waiting CPU
    cpu_req  = 1'b1;
    cpu_addr = 8'h01;
    ldr_req  = 1'b1;
    ldr_we   = 1'b1;
    ldr_lock = 1'b1;
    nw       = 0;
    for (int i = 0; i < 4; i++) begin
      ldr_addr  = 8'(8'h20 + nw);
      ldr_wdata = 8'(8'h50 + nw);
      settle();
`ifdef BURST_LOCK_EN
      exp_ldr = 1'b1;
`else
      exp_ldr = ((i % 2) == 0);
`endif
      check_eq($sformatf("t5_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(!exp_ldr));
      check_eq($sformatf("t5_ldr_gnt%0d", i), 32'(ldr_gnt), 32'(exp_ldr));
      check_eq($sformatf("t5_mem_we%0d", i), 32'(mem_we), 32'(exp_ldr));
      if (exp_ldr) nw++;
      tick();
    end
    ldr_lock  = 1'b0;
    ldr_addr  = 8'(8'h20 + nw);
    ldr_wdata = 8'(8'h50 + nw);
    settle();
`ifdef BURST_LOCK_EN
    check_eq("t5_unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("t5_unlock_ldr_gnt", 32'(ldr_gnt), 32'd0);
`else
    check_eq("t5_unlock_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_eq("t5_unlock_ldr_gnt", 32'(ldr_gnt), 32'd1);
`endif
    tick();
    idle_inputs();
    tick();

    // Read back the first burst word through the loader port
    ldr_req  = 1'b1;
    ldr_we   = 1'b0;
    ldr_addr = 8'h20;
    settle();
    check_eq("t5_rb_ldr_gnt", 32'(ldr_gnt), 32'd1);
    tick();
    idle_inputs();
    check_eq("t5_rb_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
    check_eq("t5_rb_ldr_rdata", 32'(ldr_rdata), 32'h50);
    check_eq("t5_rb_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prog_arb

// File: doc/prog_arb.md
Name: prog_arb

Overview:
- Two-requester arbiter in front of the single-port program memory (PROG), which has a registered read with 1-cycle latency and read-before-write.
- Requesters: the CPU instruction fetch (read-only) and the program loader (write, or read-back for verify).
- Grants at most one access per cycle, routes the returned data word to the owner one cycle later, and keeps fairness with a round-robin pointer.

Parameters:
- ADDR_W, 8, program memory address width.
- DATA_W, 8, program memory data width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU fetch request; held until granted.
- cpu_addr  in  ADDR_W  fetch address.
- cpu_gnt  out  1  combinational grant to CPU this cycle.
- cpu_rvalid  out  1  cpu_rdata valid (registered).
- cpu_rdata  out  DATA_W  fetched word.
- ldr_req  in  1  loader request; held until granted.
- ldr_we  in  1  1 = write, 0 = read-back.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_lock  in  1  exclusive burst request; see BURST_LOCK_EN.
- ldr_gnt  out  1  combinational grant to loader.
- ldr_rvalid  out  1  ldr_rdata valid (registered).
- ldr_rdata  out  DATA_W  read-back word.
- mem_addr  out  ADDR_W  to PROG Addr.
- mem_din  out  DATA_W  to PROG din.
- mem_we  out  1  to PROG write_en.
- mem_dout  in  DATA_W  from PROG Data.

Behaviour:
- Reset and clock: one clock (clk); rst is synchronous and active-high.
- Values during and after reset:
  - cpu_rvalid = ldr_rvalid = 0; cpu_rdata = ldr_rdata pass mem_dout and are only meaningful with rvalid.
  - rr_ptr = LDR, so the CPU wins the first tie.
  - rd_pend = 0; state = ARB.
  - Grants are 0 while rst = 1.
- Arbitration, state ARB:
  - Only cpu_req: cpu_gnt = 1.
  - Only ldr_req: ldr_gnt = 1.
  - Both requesting: grant the requester not equal to rr_ptr.
  - rr_ptr is updated to the granted requester on each grant.
  - No request: no grant; mem_we = 0; mem_addr holds its last value.
- Memory mux, combinational from the grant:
  - mem_addr = addr of the winner.
  - mem_we = ldr_gnt & ldr_we.
  - mem_din = ldr_wdata.
- Read return:
  - A granted read (any CPU grant, or a loader grant with ldr_we = 0) sets rd_pend = 1 and rd_owner = winner at the clock edge.
  - Next cycle: the owner's rvalid = 1 and rdata = mem_dout.
  - Throughput 1 access/cycle; back-to-back grants are legal.
- Writes produce no rvalid.
- A read of an address in the cycle after a write returns the new data.
- Reset asserted with rd_pend = 1: the pending return is dropped; no rvalid after reset.
- Requests are level-held; deasserting a request before grant is legal and leaves no side effect.
- Address/data widths pass straight through; no arithmetic.

Optional Feature:
- Macro: BURST_LOCK_EN.
- Defined:
  - State LOCK is added.
  - From ARB: ldr_gnt with ldr_lock = 1 moves to LOCK.
  - In LOCK: only the loader is granted (CPU stalls, cpu_gnt = 0) until a cycle with ldr_lock = 0 returns to ARB.
  - Exiting LOCK sets rr_ptr = LDR, so the CPU wins next.
  - Reset returns to ARB.
- Undefined: ldr_lock is ignored; pure round-robin.

Decomposition:
- Package prog_arb_pkg holds:
  - owner encoding: OWN_CPU = 1'b0, OWN_LDR = 1'b1;
  - state encoding: ST_ARB, ST_LOCK.
- No sub-module; the arbiter and the return tag live in one module.

Test Plan:
1. Reset then cpu_req alone, cpu_addr = 8'h05, memory [5] = 8'h3C → cpu_gnt same cycle, mem_we = 0, cpu_rvalid = 1 with cpu_rdata = 8'h3C the next cycle; ldr_rvalid stays 0.
2. Both requesting continuously (cpu 8'h01, ldr read 8'h02) → grants alternate CPU, LDR, CPU, LDR…; each rvalid goes to the correct owner one cycle after its grant.
3. Loader writes 8'hA5 to 8'h10, then the CPU reads 8'h10 in the next cycle → mem_we = 1 for one cycle, no rvalid for the write, cpu_rdata = 8'hA5.
4. rst asserted in the cycle after a granted CPU read → cpu_rvalid = 0, rr_ptr = LDR; the first contested request after reset goes to the CPU.
5. With BURST_LOCK_EN: ldr_lock = 1 for 4 writes while cpu_req = 1 → cpu_gnt = 0 for all 4; the cycle ldr_lock drops, the CPU is granted. Without the macro: the same stimulus alternates grants.
6. Neither requester active for 3 cycles → no grants, mem_we = 0, no rvalid.
